hack_data_memory: RTL and testbench

- Data-memory stage consumed by the Hack cpu: takes address_m/out_m/memory_load, returns in_m in the same cycle.
- Implements the Hack memory map: general RAM, a screen region, and a keyboard register.
- Screen writes are also pushed through a small FIFO to a downstream display writer using a valid/ready handshake.

---
 rtl/hack_memory_pkg.sv | 36 +++
 rtl/screen_write_fifo.sv | 67 ++++++
 rtl/hack_data_memory.sv | 131 +++++++++++++
 tb/tb_hack_data_memory.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hack_memory_pkg.sv
// Shared constants, types and address decode for the Hack data-memory stage.
// The SCREEN_READBACK_EN build option is handled in hack_data_memory.
package hack_memory_pkg;

  localparam logic [15:0] SCREEN_BASE   = 16'h4000;
  localparam int          SCREEN_WORDS  = 8192;
  localparam logic [15:0] KEYBOARD_ADDR = 16'h6000;

  typedef struct packed {
    logic [12:0] address;
    logic [15:0] data;
  } screen_write_t;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_SCREEN,
    REGION_KEYBOARD,
    REGION_UNMAPPED
  } region_t;

  // Fixed Hack memory map; any address with bit 15 set falls through to unmapped.
  function automatic region_t decode_region(input logic [15:0] addr);
    region_t region;
    if (addr < SCREEN_BASE) begin
      region = REGION_RAM;
    end else if (addr < (SCREEN_BASE + 16'(SCREEN_WORDS))) begin
      region = REGION_SCREEN;
    end else if (addr == KEYBOARD_ADDR) begin
      region = REGION_KEYBOARD;
    end else begin
      region = REGION_UNMAPPED;
    end
    return region;
  endfunction

endpackage

// File: rtl/screen_write_fifo.sv
// Synchronous FIFO of screen writes; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is dropped and flagged.
module screen_write_fifo
  import hack_memory_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  screen_write_t            push_data,
  output logic                     full,
  output logic                     dropped,
  input  logic                     pop,
  output logic                     valid,
  output screen_write_t            head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  screen_write_t mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count_reg != '0);
  assign full    = (count_reg == FULL_COUNT);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dropped = push && full && !do_pop;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage has no reset so it can map onto plain memory.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, screen (FIFO to display writer) and keyboard register.
// Define SCREEN_READBACK_EN to build an 8K-word shadow so screen reads return data.
module hack_data_memory
  import hack_memory_pkg::*;
#(
  parameter int RAM_WORDS   = 16384,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [15:0]                   address_m,
  input  logic [15:0]                   out_m,
  input  logic                          memory_load,
  output logic [15:0]                   in_m,
  input  logic [15:0]                   keyboard_code,
  output logic                          screen_valid,
  input  logic                          screen_ready,
  output logic [12:0]                   screen_address,
  output logic [15:0]                   screen_data,
  output logic                          screen_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int RAM_AW    = $clog2(RAM_WORDS);
  localparam int SCREEN_AW = $clog2(SCREEN_WORDS);
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_WORDS);

  region_t              region;
  logic                 write_en;
  logic [RAM_AW-1:0]    ram_index;
  logic [SCREEN_AW-1:0] screen_offset;
  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_dropped;
  screen_write_t        push_entry;
  screen_write_t        head_entry;
  logic                 overflow_reg;

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] sync_reg [SYNC_STAGES];

  // A shallower RAM leaves the top of the RAM window unmapped.
  always_comb begin
    region = decode_region(address_m);
    if (region == REGION_RAM && ({1'b0, address_m} >= RAM_LIMIT)) begin
      region = REGION_UNMAPPED;
    end
  end

  assign write_en      = memory_load && !reset;
  assign ram_index     = address_m[RAM_AW-1:0];
  assign screen_offset = address_m[SCREEN_AW-1:0];
  assign fifo_push     = write_en && (region == REGION_SCREEN);
  assign push_entry    = '{address: screen_offset, data: out_m};

  always_ff @(posedge clock) begin
    if (write_en && region == REGION_RAM) begin
      ram[ram_index] <= out_m;
    end
  end

`ifdef SCREEN_READBACK_EN
  logic [15:0] shadow [SCREEN_WORDS];

  // Shadow follows every push attempt, including ones the FIFO drops.
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      shadow[screen_offset] <= out_m;
    end
  end
`endif

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clock) begin
        if (reset) begin
          sync_reg[gi] <= '0;
        end else if (gi == 0) begin
          sync_reg[gi] <= keyboard_code;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  // Zero-latency read so the cpu ALU sees M in the same cycle.
  always_comb begin
    in_m = '0;
    case (region)
      REGION_RAM:      in_m = ram[ram_index];
`ifdef SCREEN_READBACK_EN
      REGION_SCREEN:   in_m = shadow[screen_offset];
`endif
      REGION_KEYBOARD: in_m = sync_reg[SYNC_STAGES-1];
      default:         in_m = '0;
    endcase
  end

  screen_write_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .full      (fifo_full),
    .dropped   (fifo_dropped),
    .pop       (screen_ready),
    .valid     (screen_valid),
    .head      (head_entry),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (fifo_dropped) begin
      overflow_reg <= 1'b1;
    end
  end

  assign screen_overflow = overflow_reg;
  assign screen_address  = head_entry.address;
  assign screen_data     = head_entry.data;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory: RAM, unmapped, screen FIFO, overflow,
// full-with-pop, keyboard latency and reset behaviour.
module tb_hack_data_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address_m;
  logic [15:0] out_m;
  logic        memory_load;
  logic [15:0] in_m;
  logic [15:0] keyboard_code;
  logic        screen_valid;
  logic        screen_ready;
  logic [12:0] screen_address;
  logic [15:0] screen_data;
  logic        screen_overflow;
  logic [2:0]  fifo_count;

  int tests  = 0;
  int failed = 0;

  hack_data_memory dut (
    .clock           (clock),
    .reset           (reset),
    .address_m       (address_m),
    .out_m           (out_m),
    .memory_load     (memory_load),
    .in_m            (in_m),
    .keyboard_code   (keyboard_code),
    .screen_valid    (screen_valid),
    .screen_ready    (screen_ready),
    .screen_address  (screen_address),
    .screen_data     (screen_data),
    .screen_overflow (screen_overflow),
    .fifo_count      (fifo_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
      $display("[TB] %-20s observed=%h expected=%h ok", tag, observed, expected);
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic write(input logic [15:0] addr, input logic [15:0] data);
    address_m   = addr;
    out_m       = data;
    memory_load = 1'b1;
    tick();
    memory_load = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    address_m     = 16'h0000;
    out_m         = 16'h0000;
    memory_load   = 1'b0;
    keyboard_code = 16'h0000;
    screen_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    address_m = 16'h6000;
    #1;
    check("reset_valid", 32'(screen_valid), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_overflow", 32'(screen_overflow), 32'd0);
    check("reset_keyboard", 32'(in_m), 32'h0);

    // RAM write then read, read-during-write, top RAM word
    write(16'h0010, 16'h1234);
    #1;
    check("ram_read", 32'(in_m), 32'h1234);
    address_m = 16'h0010; out_m = 16'h5678; memory_load = 1'b1;
    #1;
    check("ram_rdw_old", 32'(in_m), 32'h1234);
    tick();
    memory_load = 1'b0;
    #1;
    check("ram_rdw_new", 32'(in_m), 32'h5678);
    write(16'h0010, 16'h1234);
    write(16'h3FFF, 16'hBEEF);
    #1;
    check("ram_top", 32'(in_m), 32'hBEEF);

    // Unmapped writes ignored, reads return 0
    write(16'h7000, 16'hFFFF);
    #1;
    check("unmapped_7000", 32'(in_m), 32'h0);
    write(16'h8010, 16'hFFFF);
    #1;
    check("unmapped_8010", 32'(in_m), 32'h0);
    address_m = 16'h0010;
    #1;
    check("ram_after_unmapped", 32'(in_m), 32'h1234);

    // Single screen write
    write(16'h4005, 16'hAAAA);
    #1;
    check("scr_valid", 32'(screen_valid), 32'd1);
    check("scr_address", 32'(screen_address), 32'd5);
    check("scr_data", 32'(screen_data), 32'hAAAA);
    check("scr_count", 32'(fifo_count), 32'd1);
`ifdef SCREEN_READBACK_EN
    check("scr_readback", 32'(in_m), 32'hAAAA);
`else
    check("scr_readback_off", 32'(in_m), 32'h0);
`endif
    screen_ready = 1'b1;
    tick();
    screen_ready = 1'b0;
    #1;
    check("scr_drained_valid", 32'(screen_valid), 32'd0);
    check("scr_drained_count", 32'(fifo_count), 32'd0);

    // Overflow: five writes into a four-deep FIFO
    for (int i = 0; i < 5; i++) write(16'h4000 + 16'(i), 16'h0100 + 16'(i));
    #1;
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_flag", 32'(screen_overflow), 32'd1);
    tick();
    check("ovf_head_held", 32'(screen_address), 32'd0);
    check("ovf_data_held", 32'(screen_data), 32'h0100);
    screen_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("ovf_pop%0d_addr", i), 32'(screen_address), i);
      check($sformatf("ovf_pop%0d_data", i), 32'(screen_data), 32'h0100 + i);
      tick();
    end
    screen_ready = 1'b0;
    #1;
    check("ovf_empty_valid", 32'(screen_valid), 32'd0);
    check("ovf_sticky", 32'(screen_overflow), 32'd1);

    // Clear overflow, then full FIFO with simultaneous push and pop
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("ovf_cleared", 32'(screen_overflow), 32'd0);
    for (int i = 0; i < 4; i++) write(16'h4000 + 16'(i), 16'h0200 + 16'(i));
    screen_ready = 1'b1;
    write(16'h4010, 16'h0210);
    screen_ready = 1'b0;
    #1;
    check("pp_count", 32'(fifo_count), 32'd4);
    check("pp_overflow", 32'(screen_overflow), 32'd0);
    check("pp_head", 32'(screen_address), 32'd1);
    screen_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #1;
    check("pp_last_addr", 32'(screen_address), 32'h10);
    check("pp_last_data", 32'(screen_data), 32'h0210);
    tick();
    screen_ready = 1'b0;
    #1;
    check("pp_empty", 32'(screen_valid), 32'd0);

    // Keyboard: visible two cycles after the change
    address_m = 16'h6000;
    keyboard_code = 16'h0041;
    #1;
    check("kbd_cycle_n", 32'(in_m), 32'h0);
    tick();
    check("kbd_cycle_n1", 32'(in_m), 32'h0);
    tick();
    check("kbd_cycle_n2", 32'(in_m), 32'h0041);
    write(16'h6000, 16'h9999);
    #1;
    check("kbd_write_ignored", 32'(in_m), 32'h0041);

    // Reset mid-handshake with three entries queued
    for (int i = 0; i < 3; i++) write(16'h4008 + 16'(i), 16'h0300 + 16'(i));
    #1;
    check("rst_pre_count", 32'(fifo_count), 32'd3);
    reset = 1'b1;
    screen_ready = 1'b1;
    address_m = 16'h0010; out_m = 16'hDEAD; memory_load = 1'b1;
    tick();
    reset = 1'b0;
    memory_load = 1'b0;
    screen_ready = 1'b0;
    #1;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_valid", 32'(screen_valid), 32'd0);
    check("rst_overflow", 32'(screen_overflow), 32'd0);
    check("rst_ram_kept", 32'(in_m), 32'h1234);
    address_m = 16'h6000;
    #1;
    check("rst_keyboard", 32'(in_m), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
